// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI3 SRAM responder.
// Holds the burst and response encodings, the read/write FSM state types,
// the data-path widths and the per-beat address-advance helper.
package axi_slave_pkg;

  localparam int DATA_BITS = 32;
  localparam int STRB_BITS = DATA_BITS / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  // Byte address of the next beat. FIXED holds the address; INCR and WRAP
  // both step by the transfer size (WRAP is deliberately treated as INCR).
  // Overflow past the array depth is harmless: only the word-index bits
  // are used, so the index wraps modulo the depth.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_sram_slave_mem.sv
// Word-addressed storage array for the AXI3 SRAM responder.
// Ports:
//   clk    - write clock
//   we     - write enable for this cycle
//   waddr  - word index written at the rising edge
//   wdata  - write data
//   wstrb  - byte-lane enables, one per byte of wdata
//   raddr  - word index read combinationally
//   rdata  - contents of raddr (pre-write value in a same-word cycle)
module axi_sram_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [STRB_BITS-1:0] wstrb,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset branch on purpose; clearing thousands of
  // words would turn a RAM into flops, and software never relies on it.
  // NOTE: non-blocking writes keep the async read port showing the old word
  // for the rest of the cycle in which the word is written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_BITS; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by an on-chip 32-bit word array.
// Read and write channels run independent FSMs over a memory with one
// async read port and one byte-enabled synchronous write port.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   ar*  / arready            - read address channel (lock/cache/prot unused)
//   r*   / rready             - read data channel, rresp always OKAY
//   aw*  / awready            - write address channel (lock/cache/prot unused)
//   w*   / wready             - write data channel (wid unused)
//   b*   / bready             - write response channel
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Sideband fields carry no meaning for a flat SRAM.
  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // ---------------- read channel ----------------
  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_count;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] mem_rdata;

  // rvalid/rlast decode straight from state registers, so they cannot
  // glitch with rready and stay stable while the master stalls.
  assign rvalid = (r_state == R_DATA);
  assign rlast  = rvalid && (r_count == r_len);
  assign rdata  = rvalid ? mem_rdata : '0;
  assign rresp  = RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      case (r_state)
        R_IDLE: begin
          // Held low for the first cycle out of reset, then high while idle.
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_count <= '0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              arready <= 1'b1;
            end else begin
              r_count <= r_count + 8'd1;
              r_addr  <= next_addr(r_addr, r_size, r_burst);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_count;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        mem_we;
  logic        beat_err;

  assign wready   = (w_state == W_DATA);
  assign bvalid   = (w_state == W_RESP);
  assign mem_we   = wready && wvalid;
  // A beat is malformed when wlast and the expected last beat disagree.
  // The error is sticky, so a counter wrap on very long overruns is harmless.
  assign beat_err = (wlast != (w_count == w_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_addr  <= '0;
      w_len   <= '0;
      w_count <= '0;
      w_size  <= '0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_count <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_addr  <= next_addr(w_addr, w_size, w_burst);
            w_count <= w_count + 8'd1;
            if (beat_err) w_err <= 1'b1;
            if (wlast) begin
              bresp   <= (w_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_sram_slave_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_addr[ADDR_BITS+1:2]),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (r_addr[ADDR_BITS+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a word-array model plus queues of
// expected read beats and write responses, checked every cycle at negedge.
module tb_axi_sram_slave;
  import axi_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock = 2'b00;
  logic [3:0]  arcache = 4'h0;
  logic [2:0]  arprot = 3'b000;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock = 2'b00;
  logic [3:0]  awcache = 4'h0;
  logic [2:0]  awprot = 3'b000;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid = 4'h0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_slave #(.ADDR_BITS(12)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    logic [11:0] idx;
    logic [3:0]  id;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic [31:0] model_mem [4096];
  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] wbuf [256];
  logic [31:0] rbuf [256];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte address of beat b from the burst rules, in closed form.
  function automatic logic [11:0] beat_idx(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst, input int b);
    logic [31:0] a;
    a = (burst == BURST_FIXED) ? addr : addr + 32'(b) * (32'd1 << size);
    return a[13:2];
  endfunction

  function automatic logic pick_rready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          check("r_unexpected", rvalid, 1'b0);
        end else begin
          check("rdata", rdata, model_mem[rq[0].idx]);
          check("rid", rid, rq[0].id);
          check("rlast", rlast, rq[0].last);
          check("rresp", rresp, RESP_OKAY);
          if (rready) void'(rq.pop_front());
        end
      end else begin
        check("rlast_idle", rlast, 1'b0);
      end
      if (bvalid) begin
        if (bq.size() == 0) begin
          check("b_unexpected", bvalid, 1'b0);
        end else begin
          check("bid", bid, bq[0].id);
          check("bresp", bresp, bq[0].resp);
          if (bready) void'(bq.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    rready = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0;
    rq.delete();
    bq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", arready, 1'b0);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rid", rid, 4'h0);
    check("rst_bid", bid, 4'h0);
    check("rst_resp", {rresp, bresp}, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready_low", arready, 1'b0);
    check("post_rst_awready_low", awready, 1'b0);
    @(negedge clk);
    check("post_rst_arready_high", arready, 1'b1);
    check("post_rst_awready_high", awready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Starts and ends just after a rising edge. Beats come from wbuf.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input logic [3:0] strb, input bit rand_strb, input bit gaps,
                             output logic [1:0] resp);
    int t;
    logic [3:0]  s;
    logic [11:0] ix;
    logic [1:0]  exp_resp;
    bexp_t e;
    resp = 2'bxx;
    exp_resp = (nbeats - 1 != int'(len)) ? RESP_SLVERR : RESP_OKAY;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 1000) begin @(negedge clk); t++; end
    if (!awready) begin check("aw_timeout", awready, 1'b1); awvalid = 1'b0; return; end
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("wready_latency", wready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s = rand_strb ? 4'($urandom) : strb;
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = s; wlast = (i == nbeats - 1);
      t = 0;
      @(negedge clk);
      while (!wready && t < 1000) begin @(negedge clk); t++; end
      if (!wready) begin check("w_timeout", wready, 1'b1); wvalid = 1'b0; return; end
      @(posedge clk);
      ix = beat_idx(addr, size, burst, i);
      for (int l = 0; l < 4; l++) if (s[l]) model_mem[ix][8*l +: 8] = wbuf[i][8*l +: 8];
      #1 wvalid = 1'b0; wlast = 1'b0;
    end
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    @(negedge clk);
    check("bvalid_latency", bvalid, 1'b1);
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 1000) begin @(negedge clk); t++; end
    if (!bvalid) begin check("b_timeout", bvalid, 1'b1); bready = 1'b0; return; end
    resp = bresp;
    check("bresp_seen", bresp, exp_resp);
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check("awready_after_b", awready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Starts just after a rising edge. Stops after stop_at handshakes; if that
  // is short of the burst it returns at the negedge before the last edge.
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode,
                            input int stop_at);
    int t, n, k;
    rexp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      e.idx = beat_idx(addr, size, burst, b);
      e.id = id;
      e.last = (b == int'(len));
      rq.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 1000) begin @(negedge clk); t++; end
    if (!arready) begin check("ar_timeout", arready, 1'b1); arvalid = 1'b0; return; end
    @(posedge clk); #1 arvalid = 1'b0;
    k = 0;
    rready = pick_rready(mode, k);
    @(negedge clk);
    check("rvalid_latency", rvalid, 1'b1);
    n = 0;
    while (1) begin
      if (rvalid && rready) begin rbuf[n] = rdata; n++; end
      if (n >= stop_at || k > 2000) break;
      @(posedge clk); #1 k++;
      rready = pick_rready(mode, k);
      @(negedge clk);
    end
    if (k > 2000) check("r_timeout", n, stop_at);
    if (n < int'(len) + 1) return;
    if (mode == 0) check("r_burst_cycles", k, int'(len));
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    check("arready_after_r", arready, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp;
    logic [31:0] ra, wa;
    logic [7:0]  rl, wl;
    logic [2:0]  rs, ws;
    logic [1:0]  rb, wb;
    int          op, wn, rmode;

    do_reset();

    // Preload every word so all later reads have a defined model value;
    // random upper address bits exercise aliasing.
    for (int base = 0; base < 4096; base += 16) begin
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      write_burst(4'($urandom), {18'($urandom), 12'(base), 2'b00}, 8'd15, 3'd2, BURST_INCR,
                  16, 4'hF, 1'b0, 1'b0, resp);
    end

    // 16-beat INCR line write and read-back.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
    write_burst(4'h0, 32'h1FC0_0040, 8'd15, 3'd2, BURST_INCR, 16, 4'hF, 1'b0, 1'b0, resp);
    check("line_bresp", resp, 2'b00);
    read_burst(4'h0, 32'h1FC0_0040, 8'd15, 3'd2, BURST_INCR, 0, 16);
    for (int i = 0; i < 16; i++) check("line_rdata", rbuf[i], 32'(i));

    // Narrow byte write into a known word.
    wbuf[0] = 32'h1122_3344;
    write_burst(4'h3, 32'h0000_0100, 8'd0, 3'd2, BURST_FIXED, 1, 4'hF, 1'b0, 1'b0, resp);
    wbuf[0] = 32'hAB00_0000;
    write_burst(4'h3, 32'h0000_0103, 8'd0, 3'd0, BURST_FIXED, 1, 4'b1000, 1'b0, 1'b0, resp);
    check("narrow_model", model_mem[12'h040], 32'hAB22_3344);
    read_burst(4'h7, 32'h0000_0100, 8'd0, 3'd2, BURST_FIXED, 0, 1);
    check("narrow_rdata", rbuf[0], 32'hAB22_3344);

    // Read with rready toggling every other cycle.
    read_burst(4'h9, 32'h0000_0400, 8'd15, 3'd2, BURST_INCR, 1, 16);
    check("toggle_beat15", rbuf[15], model_mem[12'h10F]);

    // Early wlast: only 8 beats land, response is SLVERR.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hA5A5_0000 + 32'(i);
    write_burst(4'h1, 32'h0000_2000, 8'd15, 3'd2, BURST_INCR, 16, 4'hF, 1'b0, 1'b0, resp);
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h5A5A_0000 + 32'(i);
    write_burst(4'h2, 32'h0000_2000, 8'd15, 3'd2, BURST_INCR, 8, 4'hF, 1'b0, 1'b0, resp);
    check("early_wlast_bresp", resp, 2'b10);
    read_burst(4'h2, 32'h0000_2000, 8'd15, 3'd2, BURST_INCR, 0, 16);
    for (int i = 0; i < 16; i++)
      check("early_wlast_rdata", rbuf[i], (i < 8) ? 32'h5A5A_0000 + 32'(i) : 32'hA5A5_0000 + 32'(i));

    // Concurrent read and write of one line, write one cycle ahead.
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    fork
      write_burst(4'h4, 32'h0000_3000, 8'd15, 3'd2, BURST_INCR, 16, 4'hF, 1'b0, 1'b0, resp);
      begin
        @(posedge clk); #1;
        read_burst(4'h5, 32'h0000_3000, 8'd15, 3'd2, BURST_INCR, 0, 16);
      end
    join
    check("concurrent_bresp", resp, 2'b00);

    // Reset in the middle of a read burst.
    read_burst(4'h6, 32'h0000_0800, 8'd15, 3'd2, BURST_INCR, 0, 5);
    @(posedge clk); #1 rst = 1'b1; rready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rq.delete();
    bq.delete();
    @(negedge clk);
    check("rvalid_after_rst", rvalid, 1'b0);
    check("arready_after_rst", arready, 1'b0);
    @(posedge clk); #1;
    read_burst(4'hA, 32'h0000_0800, 8'd3, 3'd2, BURST_INCR, 0, 4);
    check("after_rst_beat0", rbuf[0], model_mem[12'h200]);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      ra = $urandom; wa = $urandom;
      rl = 8'($urandom_range(0, 15)); wl = 8'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 2));  ws = 3'($urandom_range(0, 2));
      rb = 2'($urandom_range(0, 2));  wb = 2'($urandom_range(0, 2));
      rmode = $urandom_range(0, 2);
      wn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(wl) + 3) : int'(wl) + 1;
      for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
      case (op)
        0: write_burst(4'($urandom), wa, wl, ws, wb, wn, 4'hF, 1'b1, 1'b1, resp);
        1: read_burst(4'($urandom), ra, rl, rs, rb, rmode, int'(rl) + 1);
        default: fork
          write_burst(4'($urandom), wa, wl, ws, wb, wn, 4'hF, 1'b1, 1'b1, resp);
          read_burst(4'($urandom), ra, rl, rs, rb, rmode, int'(rl) + 1);
        join
      endcase
    end

    repeat (3) @(posedge clk);
    check("rq_drained", rq.size(), 0);
    check("bq_drained", bq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
